// File: rtl/dg_checker.sv
// Pattern checker mirroring the data generator: takes the same command
// (pattern, seed, length), regenerates the expected stream beat by beat and
// compares it with what the generator actually produced.
//
// state | meaning
// IDLE  | waiting for a command, cfg_ready high
// RUN   | consuming beats, in_ready high, comparing against expected register
// DONE  | one-cycle result strobe, results frozen until next command
module dg_checker #(
  parameter int PATTERN_DATA_WIDTH = 32,
  parameter logic [PATTERN_DATA_WIDTH-1:0] PRBS_TAPS = PATTERN_DATA_WIDTH'(32'h8020_0003)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [2:0]                    cfg_pattern,
  input  logic [PATTERN_DATA_WIDTH-1:0] cfg_data,
  input  logic [7:0]                    cfg_length,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PATTERN_DATA_WIDTH-1:0] in_data,
  output logic                          done,
  output logic                          pass,
  output logic                          cfg_err,
  output logic [7:0]                    err_count,
  output logic [7:0]                    first_err_idx,
  output logic [PATTERN_DATA_WIDTH-1:0] first_err_data
);

  localparam int W = PATTERN_DATA_WIDTH;

  localparam logic [2:0] PAT_FIXED = 3'd1;
  localparam logic [2:0] PAT_ADDR  = 3'd2;
  localparam logic [2:0] PAT_WALK1 = 3'd3;
  localparam logic [2:0] PAT_WALK0 = 3'd4;
  localparam logic [2:0] PAT_PRBS  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [2:0]     pattern;
  logic [7:0]     length;
  logic [7:0]     idx;
  logic [W-1:0]   expected;
  logic           cfg_illegal;
  logic           beat_mismatch;
  logic           last_beat;

  // Beat-0 value; walking patterns start at bit 0, prbs never seeds with zero
  // because the all-zero state would lock the LFSR.
  function automatic logic [W-1:0] first_value(input logic [2:0] pat, input logic [W-1:0] seed);
    logic [W-1:0] one;
    one = {{(W-1){1'b0}}, 1'b1};
    case (pat)
      PAT_WALK1: first_value = one;
      PAT_WALK0: first_value = ~one;
      PAT_PRBS:  first_value = (seed == '0) ? '1 : seed;
      default:   first_value = seed;
    endcase
  endfunction

  // Advance from beat i to beat i+1; a left rotate keeps walk patterns at
  // position i mod W without a separate modulo counter.
  function automatic logic [W-1:0] next_value(input logic [2:0] pat, input logic [W-1:0] cur);
    case (pat)
      PAT_ADDR:  next_value = cur + {{(W-1){1'b0}}, 1'b1};
      PAT_WALK1,
      PAT_WALK0: next_value = {cur[W-2:0], cur[W-1]};
      PAT_PRBS:  next_value = {cur[W-2:0], ^(cur & PRBS_TAPS)};
      default:   next_value = cur;
    endcase
  endfunction

  assign cfg_illegal   = (cfg_pattern == 3'd0) || (cfg_pattern > PAT_PRBS);
  assign beat_mismatch = (in_data != expected);
  assign last_beat     = (idx == (length - 8'd1));

  // Sequencer, comparator and result registers in one block so every output is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      pattern        <= 3'd0;
      length         <= 8'd0;
      idx            <= 8'd0;
      expected       <= '0;
      cfg_ready      <= 1'b1;
      in_ready       <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      cfg_err        <= 1'b0;
      err_count      <= 8'd0;
      first_err_idx  <= 8'd0;
      first_err_data <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            pattern        <= cfg_pattern;
            length         <= cfg_length;
            idx            <= 8'd0;
            expected       <= first_value(cfg_pattern, cfg_data);
            err_count      <= 8'd0;
            first_err_idx  <= 8'd0;
            first_err_data <= '0;
            cfg_err        <= cfg_illegal;
            cfg_ready      <= 1'b0;
            if (cfg_illegal || (cfg_length == 8'd0)) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= !cfg_illegal;
            end else begin
              state    <= RUN;
              in_ready <= 1'b1;
              pass     <= 1'b0;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            if (beat_mismatch) begin
              if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
              end
              if (err_count == 8'd0) begin
                first_err_idx  <= idx;
                first_err_data <= in_data;
              end
            end
            expected <= next_value(pattern, expected);
            idx      <= idx + 8'd1;
            if (last_beat) begin
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
              pass     <= (err_count == 8'd0) && !beat_mismatch && !cfg_err;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dg_checker.md
Name: dg_checker

Overview:
- Pattern checker downstream of the data generator (dg). Accepts the same command the generator receives (seed data, pattern, length), then consumes the generator's output stream. Computes the expected word for every beat, compares it with the received word, and reports pass/fail, error count and first-mismatch details.
- Closes the loop for dg_pkg random tests: every command issued to the generator is mirrored to this block.

Parameters:
- PATTERN_DATA_WIDTH, 32, data word width. Legal value for prbs is 32.
- PRBS_TAPS, 32'h8020_0003, LFSR tap mask (x^32+x^22+x^2+x+1).

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  command valid.
- cfg_ready  out  1  command accepted when valid&ready.
- cfg_pattern  in  3  dg_pkg pattern_t: fixed=1, addr=2, walk1=3, walk0=4, prbs=5.
- cfg_data  in  PATTERN_DATA_WIDTH  seed word.
- cfg_length  in  8  number of beats to check.
- in_valid  in  1  stream beat valid.
- in_ready  out  1  beat accepted when valid&ready.
- in_data  in  PATTERN_DATA_WIDTH  received word.
- done  out  1  one-cycle pulse: check complete.
- pass  out  1  result of last check, held until next command accepted.
- cfg_err  out  1  last command had illegal pattern, held like pass.
- err_count  out  8  mismatching beats in last check, saturating at 255.
- first_err_idx  out  8  beat index of first mismatch.
- first_err_data  out  PATTERN_DATA_WIDTH  received word at first mismatch.

Behaviour:
- Reset (async, reset_n=0): state IDLE.
  - cfg_ready=1, in_ready=0, done=0, pass=0, cfg_err=0, err_count=0, first_err_idx=0, first_err_data=0.
  - Internal beat counter and expected register are cleared.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - cfg_ready=1, in_ready=0.
  - On a cfg handshake, the block latches pattern and length, clears err_count, first_err_*, pass and cfg_err, and loads the expected register with the beat-0 value.
  - If the pattern is illegal (0, 6, 7) or length=0, next state is DONE; otherwise RUN.
- RUN:
  - cfg_ready=0, in_ready=1.
  - Each in handshake compares in_data with the expected register in the same cycle.
  - On a mismatch, err_count increments (saturating). If it is the first mismatch, the block captures first_err_idx=beat index and first_err_data=in_data.
  - The expected register then advances and the beat index increments.
  - When the accepted beat has index length-1, next state is DONE.
  - Cycles without in_valid are stalls: no state change.
- DONE (one cycle):
  - done=1, cfg_ready=0, in_ready=0.
  - pass=1 iff cfg_err=0 and err_count=0. pass updates on this same edge and is visible with done.
  - cfg_err=1 for an illegal pattern.
  - Next state is IDLE.
- Latency: done is asserted on the cycle after the last beat handshake, or on the cycle after the cfg handshake when length=0 or the pattern is illegal.
- Expected value for beat i (W=PATTERN_DATA_WIDTH, seed=cfg_data):
  - fixed: seed.
  - addr: (seed + i) mod 2^W, wrapping at all-ones.
  - walk1: 1 << (i mod W), seed ignored.
  - walk0: ~(1 << (i mod W)).
  - prbs:
    - Beat 0 is seed, or all-ones if seed=0.
    - next = {cur[W-2:0], ^(cur & PRBS_TAPS)}.
- Illegal pattern: no beats are consumed, even if in_valid is high.
- Back-to-back operation: a new command is accepted only in IDLE, so at least one idle cycle separates checks.
- pass, cfg_err, err_count and first_err_* remain stable from done until the next cfg handshake.
- reset_n deassertion mid-RUN returns the block to the reset state immediately. Beats already accepted are discarded.
- The beat counter is 8 bits. Because the maximum length is 255, the index never wraps within a check.

Test Plan:
- fixed, seed 32'hA5A5_A5A5, length 4, stream of 4×A5A5A5A5 -> done 1 cycle after beat 3, pass=1, err_count=0.
- addr, seed 32'hFFFF_FFFE, length 3, stream FFFFFFFE, FFFFFFFF, 00000000 -> pass=1, which checks wrap-around.
- prbs, seed 1, length 3, stream 00000001, 00000003, 00000007 -> pass=0, err_count=1, first_err_idx=2, first_err_data=00000007. Expected beat 2 is 00000006.
- walk0, length 34, correct stream with in_valid toggling 50%:
  - Beat 32 must equal FFFFFFFE.
  - Result: pass=1; in_ready stays high throughout RUN.
- cfg_pattern=3'b110, length 10, in_valid held high -> done next cycle, cfg_err=1, pass=0, no in handshakes. Separately, length=0 with a legal pattern -> done next cycle, pass=1.
- Reset asserted after 2 of 5 addr beats -> all outputs at reset values, cfg_ready=1. A following fixed length-1 check passes.
